pipe_flush_ctrl: RTL and testbench
==================================

# pipe_flush_ctrl

Parametrised pipeline hazard controller; successor to the single-output jump clear. Drives a per-stage `stall`/`clear` vector for an N-stage in-order pipeline from five event sources: jump, trap, load-use, multi-cycle EX op, and memory wait. Registered state tracks multi-cycle countdown and redirects deferred by a memory freeze. Sits beside the PC/pipeline-register bank; every pipeline register consumes its own stall/clear bit.

## Interface
- `STAGES`, 5, number of pipeline registers; index 0 = PC, i = input register of stage i (1 ID, 2 EX, 3 MEM, 4 WB).
- `JUMP_STAGE`, 2, stage that resolves jumps and hosts multi-cycle ops.
- `TRAP_STAGE`, 3, stage that resolves traps; legal range JUMP_STAGE < TRAP_STAGE <= STAGES-2, JUMP_STAGE >= 1.
- `MC_WIDTH`, 6, width of multi-cycle length and counter.
- `clk` in 1, rising-edge clock.
- `rst` in 1, synchronous, active-high reset.
- `jump_en` in 1, taken jump resolved in JUMP_STAGE.
- `trap_en` in 1, trap resolved in TRAP_STAGE.
- `load_use` in 1, ID consumer depends on load in EX.
- `mc_start` in 1, multi-cycle op in EX begins this cycle.
- `mc_cycles` in MC_WIDTH, total EX occupancy of the op (0 treated as 1).
- `mem_wait` in 1, memory not ready; freeze whole pipe.
- `stall` out STAGES, bit i: register i holds.
- `clear` out STAGES, bit i: register i loads a bubble.
- `pc_hold` out 1, equals stall[0].
- `redirect_sel` out 2, 00 sequential, 01 jump target, 10 trap vector.
- `busy` out 1, state MC_BUSY or any pending flag set.

## Operation
- Registers: `state` {IDLE, MC_BUSY}, `cnt` (MC_WIDTH), `pend_jump`, `pend_trap`. Reset: IDLE, cnt 0, flags 0.
- Outputs combinational from registers and inputs. While `rst` high all outputs 0.
- Priority per cycle, first match wins:
  - mem_wait: stall all ones, clear 0, redirect 00; trap_en (or pend_trap) sets pend_trap and clears pend_jump; jump_en sets pend_jump unless pend_trap; cnt and state frozen; mc_start ignored (source holds it).
  - trap (trap_en or pend_trap): clear[TRAP_STAGE+1:1] = 1, stall 0, redirect 10; next: IDLE, cnt 0, both flags 0.
  - jump (jump_en or pend_jump), state IDLE: clear[JUMP_STAGE:1] = 1, redirect 01; pend_jump cleared. jump_en in MC_BUSY is a protocol violation and is ignored.
  - MC_BUSY: stall[JUMP_STAGE:0] = 1, clear[JUMP_STAGE+1] = 1; cnt decrements; cnt == 1 → IDLE next.
  - mc_start, IDLE, N = max(mc_cycles,1): N >= 2 → same stall/clear as MC_BUSY this cycle; N >= 3 → MC_BUSY, cnt = N-2. N <= 2 stays IDLE.
  - load_use: stall[JUMP_STAGE-1:0] = 1, clear[JUMP_STAGE] = 1.
  - else all zero.
- stall[i] and clear[i] never both 1.
- Jump and mc_start same cycle: jump wins, mc_start ignored.

## Timing
- Zero-latency response for live events (same cycle as input).
- Deferred redirect: applied in first cycle with mem_wait low, regardless of source still asserting.
- Multi-cycle op: stall asserted exactly N-1 consecutive non-frozen cycles starting at mc_start; mem_wait cycles extend the window without counting.
- Reset mid-op: rst in MC_BUSY or with pending flags → IDLE, flags 0 at next edge; no redirect emitted after.

## Test plan
- Jump: jump_en one cycle in IDLE → clear=5'b00110, stall=0, redirect_sel=01 that cycle only.
- Load-use: load_use one cycle → stall=5'b00011, clear=5'b00100, pc_hold=1.
- Multi-cycle: mc_start, mc_cycles=4 → stall=5'b00111, clear=5'b01000 for exactly 3 cycles, busy high cycles 2-3; mc_cycles=0 and 1 → no stall; 2 → one cycle.
- Freeze + deferred redirect: mem_wait high 3 cycles, jump_en pulse in cycle 2 → stall=5'b11111 for 3 cycles, busy=1, then cycle 4 clear=5'b00110, redirect 01; repeat with trap_en also pulsed → cycle 4 clear=5'b11110, redirect 10, no jump redirect.
- Trap cancels MC: mc_cycles=10, trap_en in 3rd cycle → clear=5'b11110 that cycle, next cycle IDLE, stall 0.
- Reset: rst during MC_BUSY with pend flags → outputs 0 while rst, IDLE and busy=0 after.

Source files
------------

// File: rtl/pipe_flush_ctrl.sv
// Per-stage stall/clear generator for an in-order pipeline: jump, trap, load-use, multi-cycle EX, memory freeze.
// Latency: zero-cycle combinational response; backpressure: mem_wait freezes every stage and defers redirects.
module pipe_flush_ctrl #(
  parameter int STAGES     = 5,
  parameter int JUMP_STAGE = 2,
  parameter int TRAP_STAGE = 3,
  parameter int MC_WIDTH   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_en,
  input  logic                trap_en,
  input  logic                load_use,
  input  logic                mc_start,
  input  logic [MC_WIDTH-1:0] mc_cycles,
  input  logic                mem_wait,
  output logic [STAGES-1:0]   stall,
  output logic [STAGES-1:0]   clear,
  output logic                pc_hold,
  output logic [1:0]          redirect_sel,
  output logic                busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    state_t              state;
    logic [MC_WIDTH-1:0] cnt;
    logic                pend_jump;
    logic                pend_trap;
  } ctrl_t;

  localparam logic [1:0] REDIR_SEQ  = 2'b00;
  localparam logic [1:0] REDIR_JUMP = 2'b01;
  localparam logic [1:0] REDIR_TRAP = 2'b10;

  function automatic logic [STAGES-1:0] span(input int lo, input int hi);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STAGES-1:0] ALL_STALL = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] TRAP_CLR  = span(1, TRAP_STAGE + 1);
  localparam logic [STAGES-1:0] JUMP_CLR  = span(1, JUMP_STAGE);
  localparam logic [STAGES-1:0] MC_STALL  = span(0, JUMP_STAGE);
  localparam logic [STAGES-1:0] MC_CLR    = span(JUMP_STAGE + 1, JUMP_STAGE + 1);
  localparam logic [STAGES-1:0] LU_STALL  = span(0, JUMP_STAGE - 1);
  localparam logic [STAGES-1:0] LU_CLR    = span(JUMP_STAGE, JUMP_STAGE);

  localparam ctrl_t CTRL_RESET = '{state: IDLE, cnt: '0, pend_jump: 1'b0, pend_trap: 1'b0};

  ctrl_t               ctrl_q;
  ctrl_t               ctrl_d;
  logic [MC_WIDTH-1:0] mc_len;
  logic                trap_hit;
  logic                jump_hit;

  // A zero-length op still occupies EX for one cycle.
  assign mc_len   = (mc_cycles == '0) ? MC_WIDTH'(1) : mc_cycles;
  assign trap_hit = trap_en | ctrl_q.pend_trap;
  assign jump_hit = jump_en | ctrl_q.pend_jump;

  always_comb begin
    stall        = '0;
    clear        = '0;
    redirect_sel = REDIR_SEQ;
    ctrl_d       = ctrl_q;

    if (rst) begin
      ctrl_d = CTRL_RESET;
    end else if (mem_wait) begin
      // Frozen cycle: only capture redirects so they land once memory is ready.
      stall = ALL_STALL;
      if (trap_hit) begin
        ctrl_d.pend_trap = 1'b1;
        ctrl_d.pend_jump = 1'b0;
      end else if (jump_en && ctrl_q.state == IDLE) begin
        ctrl_d.pend_jump = 1'b1;
      end
    end else if (trap_hit) begin
      clear        = TRAP_CLR;
      redirect_sel = REDIR_TRAP;
      ctrl_d       = CTRL_RESET;
    end else if (jump_hit && ctrl_q.state == IDLE) begin
      clear            = JUMP_CLR;
      redirect_sel     = REDIR_JUMP;
      ctrl_d.pend_jump = 1'b0;
    end else if (ctrl_q.state == MC_BUSY) begin
      stall      = MC_STALL;
      clear      = MC_CLR;
      ctrl_d.cnt = ctrl_q.cnt - MC_WIDTH'(1);
      if (ctrl_q.cnt == MC_WIDTH'(1)) ctrl_d.state = IDLE;
    end else if (mc_start) begin
      // The start cycle is the first stalled cycle, so the counter covers N-2 more.
      if (mc_len >= MC_WIDTH'(2)) begin
        stall = MC_STALL;
        clear = MC_CLR;
      end
      if (mc_len >= MC_WIDTH'(3)) begin
        ctrl_d.state = MC_BUSY;
        ctrl_d.cnt   = mc_len - MC_WIDTH'(2);
      end
    end else if (load_use) begin
      stall = LU_STALL;
      clear = LU_CLR;
    end
  end

  assign pc_hold = stall[0];
  assign busy    = !rst && (ctrl_q.state == MC_BUSY || ctrl_q.pend_jump || ctrl_q.pend_trap);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CTRL_RESET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl: each scenario task drives vectors and checks them inline.
module tb_pipe_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       jump_en, trap_en, load_use, mc_start, mem_wait;
  logic [5:0] mc_cycles;
  logic [4:0] stall, clear;
  logic       pc_hold, busy;
  logic [1:0] redirect_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_flush_ctrl #(
    .STAGES(5), .JUMP_STAGE(2), .TRAP_STAGE(3), .MC_WIDTH(6)
  ) dut (
    .clk(clk), .rst(rst), .jump_en(jump_en), .trap_en(trap_en), .load_use(load_use),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .mem_wait(mem_wait),
    .stall(stall), .clear(clear), .pc_hold(pc_hold), .redirect_sel(redirect_sel), .busy(busy)
  );

  // Observed tuple: {stall, clear, redirect_sel, busy, pc_hold}
  logic [13:0] obs;
  assign obs = {stall, clear, redirect_sel, busy, pc_hold};

  task automatic drive(input logic j, input logic t, input logic lu, input logic ms,
                       input logic [5:0] n, input logic mw);
    jump_en = j; trap_en = t; load_use = lu; mc_start = ms; mc_cycles = n; mem_wait = mw;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle;
    drive(0, 0, 0, 0, 6'd0, 0);
    next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1, 1, 1, 1, 6'd4, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL reset_idle got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_jump;
    drive(1, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00110_01_0_0) begin
      errors++; $display("FAIL jump_live got=%b exp=%b", obs, 14'b00000_00110_01_0_0);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL jump_after got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_load_use;
    drive(0, 0, 1, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00011_00100_00_0_1) begin
      errors++; $display("FAIL load_use got=%b exp=%b", obs, 14'b00011_00100_00_0_1);
    end
    next_cycle();
    idle_cycle();
  endtask

  task automatic test_multi_cycle;
    // N=4: three stalled cycles, busy only on the two registered ones.
    drive(0, 0, 0, 1, 6'd4, 0);
    checks++;
    if (obs !== 14'b00111_01000_00_0_1) begin
      errors++; $display("FAIL mc4_c1 got=%b exp=%b", obs, 14'b00111_01000_00_0_1);
    end
    next_cycle();
    for (int c = 2; c <= 3; c++) begin
      drive(0, 0, 0, 0, 6'd0, 0);
      checks++;
      if (obs !== 14'b00111_01000_00_1_1) begin
        errors++; $display("FAIL mc4_c%0d got=%b exp=%b", c, obs, 14'b00111_01000_00_1_1);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL mc4_end got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
    // N=0 and N=1 never stall.
    for (int n = 0; n <= 1; n++) begin
      drive(0, 0, 0, 1, 6'(n), 0);
      checks++;
      if (obs !== 14'b00000_00000_00_0_0) begin
        errors++; $display("FAIL mc%0d_nostall got=%b exp=%b", n, obs, 14'b00000_00000_00_0_0);
      end
      next_cycle();
    end
    // N=2: exactly one stalled cycle, never busy.
    drive(0, 0, 0, 1, 6'd2, 0);
    checks++;
    if (obs !== 14'b00111_01000_00_0_1) begin
      errors++; $display("FAIL mc2_c1 got=%b exp=%b", obs, 14'b00111_01000_00_0_1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL mc2_c2 got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_mc_freeze;
    // N=3 with a freeze between the two counted cycles.
    drive(0, 0, 0, 1, 6'd3, 0);
    checks++;
    if (obs !== 14'b00111_01000_00_0_1) begin
      errors++; $display("FAIL mcfz_c1 got=%b exp=%b", obs, 14'b00111_01000_00_0_1);
    end
    next_cycle();
    drive(0, 0, 0, 1, 6'd3, 1);
    checks++;
    if (obs !== 14'b11111_00000_00_1_1) begin
      errors++; $display("FAIL mcfz_frozen got=%b exp=%b", obs, 14'b11111_00000_00_1_1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00111_01000_00_1_1) begin
      errors++; $display("FAIL mcfz_c2 got=%b exp=%b", obs, 14'b00111_01000_00_1_1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL mcfz_end got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_deferred(input logic with_trap);
    logic [13:0] exp_apply;
    exp_apply = with_trap ? 14'b00000_11110_10_1_0 : 14'b00000_00110_01_1_0;
    drive(0, 0, 0, 0, 6'd0, 1);
    checks++;
    if (obs !== 14'b11111_00000_00_0_1) begin
      errors++; $display("FAIL defer%0d_f1 got=%b exp=%b", with_trap, obs, 14'b11111_00000_00_0_1);
    end
    next_cycle();
    drive(1, with_trap, 0, 0, 6'd0, 1);
    checks++;
    if (obs !== 14'b11111_00000_00_0_1) begin
      errors++; $display("FAIL defer%0d_f2 got=%b exp=%b", with_trap, obs, 14'b11111_00000_00_0_1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 1);
    checks++;
    if (obs !== 14'b11111_00000_00_1_1) begin
      errors++; $display("FAIL defer%0d_f3 got=%b exp=%b", with_trap, obs, 14'b11111_00000_00_1_1);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== exp_apply) begin
      errors++; $display("FAIL defer%0d_apply got=%b exp=%b", with_trap, obs, exp_apply);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL defer%0d_after got=%b exp=%b", with_trap, obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_trap_cancels_mc;
    drive(0, 0, 0, 1, 6'd10, 0);
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00111_01000_00_1_1) begin
      errors++; $display("FAIL trapmc_busy got=%b exp=%b", obs, 14'b00111_01000_00_1_1);
    end
    next_cycle();
    drive(0, 1, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_11110_10_1_0) begin
      errors++; $display("FAIL trapmc_trap got=%b exp=%b", obs, 14'b00000_11110_10_1_0);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL trapmc_after got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_jump_beats_mc;
    drive(1, 0, 0, 1, 6'd5, 0);
    checks++;
    if (obs !== 14'b00000_00110_01_0_0) begin
      errors++; $display("FAIL jumpmc_live got=%b exp=%b", obs, 14'b00000_00110_01_0_0);
    end
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL jumpmc_after got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_op;
    drive(0, 0, 0, 1, 6'd10, 0);
    next_cycle();
    drive(0, 1, 0, 0, 6'd0, 1);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL rstmid_in got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 6'd0, 0);
    checks++;
    if (obs !== 14'b00000_00000_00_0_0) begin
      errors++; $display("FAIL rstmid_after got=%b exp=%b", obs, 14'b00000_00000_00_0_0);
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    jump_en = 0; trap_en = 0; load_use = 0; mc_start = 0; mc_cycles = '0; mem_wait = 0;
    next_cycle();
    test_reset();
    test_jump();
    test_load_use();
    test_multi_cycle();
    test_mc_freeze();
    test_deferred(1'b0);
    test_deferred(1'b1);
    test_trap_cancels_mc();
    test_jump_beats_mc();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
